alu_op_sequencer: RTL

- Multicycle control FSM that sequences the shared ALU and its operand muxes across fetch/decode/execute/memory/writeback.
- Drives the select of the ALU A-operand mux (rs1 vs instruction PC) and the B-operand mux (rs2 / imm / constant 4), plus PC, IR, memory and register-file strobes.
- Sits between the instruction register (opcode input) and the ALU datapath in the multicycle RV32I core.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_op_sequencer_if.sv | 33 +++
 rtl/alu_seq_wait_timer.sv | 28 ++
 rtl/alu_op_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the multicycle ALU operation sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic       A_RS1 = 1'b0;
    localparam logic       A_PC  = 1'b1;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Control bundle between the sequencer and the IR / memory / datapath.
interface alu_op_sequencer_if;
    logic       run;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       wb_sel;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  run, opcode, mem_ready,
        output alu_a_sel, alu_b_sel, alu_op, pc_write, pc_write_cond,
               ir_write, mem_read, mem_write, reg_write, wb_sel,
               instr_done, illegal, bus_err
    );

    modport slave (
        output run, opcode, mem_ready,
        input  alu_a_sel, alu_b_sel, alu_op, pc_write, pc_write_cond,
               ir_write, mem_read, mem_write, reg_write, wb_sel,
               instr_done, illegal, bus_err
    );
endinterface

// File: rtl/alu_seq_wait_timer.sv
// Counts consecutive memory wait cycles; flags the cycle that hits the limit.
module alu_seq_wait_timer #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_waiting,
    input  logic i_clear,
    output logic o_expired
);
    localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(WAIT_LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_waiting) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The counter holds cycles already waited, so limit-1 marks the Nth one.
    assign o_expired = (WAIT_LIMIT != 0) && i_waiting && (r_cnt == LIM_M1);
endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle RV32I control FSM driving ALU operand muxes and core strobes.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input logic                 clk,
    input logic                 rst,
    alu_op_sequencer_if.master  ctl
);
    state_t r_state;
    logic   w_waiting;
    logic   w_expired;
    logic   w_is_load;

    assign w_is_load = (ctl.opcode == OP_LOAD);
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM))
                       && !ctl.mem_ready;

    alu_seq_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_waiting (w_waiting),
        .i_clear   (!w_waiting || w_expired),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (ctl.run) r_state <= S_FETCH;
                S_FETCH: begin
                    if (w_expired)          r_state <= S_IDLE;
                    else if (ctl.mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: r_state <= S_EXEC;
                S_EXEC: begin
                    case (ctl.opcode)
                        OP_R, OP_IMM, OP_AUIPC: r_state <= S_WB;
                        OP_LOAD, OP_STORE:      r_state <= S_MEM;
                        default: r_state <= ctl.run ? S_FETCH : S_IDLE;
                    endcase
                end
                S_MEM: begin
                    if (w_expired)       r_state <= S_IDLE;
                    else if (ctl.mem_ready) begin
                        if (w_is_load)   r_state <= S_WB;
                        else r_state <= ctl.run ? S_FETCH : S_IDLE;
                    end
                end
                S_WB:     r_state <= ctl.run ? S_FETCH : S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ctl.alu_a_sel     = A_RS1;
        ctl.alu_b_sel     = B_RS2;
        ctl.alu_op        = ALU_ADD;
        ctl.pc_write      = 1'b0;
        ctl.pc_write_cond = 1'b0;
        ctl.ir_write      = 1'b0;
        ctl.mem_read      = 1'b0;
        ctl.mem_write     = 1'b0;
        ctl.reg_write     = 1'b0;
        ctl.wb_sel        = 1'b0;
        ctl.instr_done    = 1'b0;
        ctl.illegal       = 1'b0;
        ctl.bus_err       = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_expired) begin
                    ctl.bus_err = 1'b1;
                end else begin
                    ctl.mem_read  = 1'b1;
                    ctl.alu_a_sel = A_PC;
                    ctl.alu_b_sel = B_FOUR;
                    ctl.ir_write  = ctl.mem_ready;
                    ctl.pc_write  = ctl.mem_ready;
                end
            end
            S_DECODE: begin
                ctl.alu_a_sel = A_PC;
                ctl.alu_b_sel = B_IMM;
            end
            S_EXEC: begin
                case (ctl.opcode)
                    OP_R:    ctl.alu_op = ALU_FUNCT;
                    OP_IMM: begin
                        ctl.alu_b_sel = B_IMM;
                        ctl.alu_op    = ALU_FUNCT;
                    end
                    OP_LOAD, OP_STORE: ctl.alu_b_sel = B_IMM;
                    OP_BRANCH: begin
                        ctl.alu_op        = ALU_SUB;
                        ctl.pc_write_cond = 1'b1;
                        ctl.instr_done    = 1'b1;
                    end
                    OP_AUIPC: begin
                        ctl.alu_a_sel = A_PC;
                        ctl.alu_b_sel = B_IMM;
                    end
                    default: begin
                        ctl.illegal    = 1'b1;
                        ctl.instr_done = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (w_expired) begin
                    ctl.bus_err = 1'b1;
                end else if (w_is_load) begin
                    ctl.mem_read = 1'b1;
                end else begin
                    ctl.mem_write  = 1'b1;
                    ctl.instr_done = ctl.mem_ready;
                end
            end
            S_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.wb_sel     = w_is_load;
                ctl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
